// File: rtl/sparse_mult_by_a_pkg.sv
// Shared constants and types for the sparse GF(2) row-times-frame block.
// Lane width, default frame length/mask and the frame index type.
package sparse_mult_by_a_pkg;

  localparam int LANE_W = 32;
  localparam int FRAME_LEN = 11;
  localparam logic [FRAME_LEN-1:0] A_MASK = 11'b100_0000_0000;
  localparam int IDX_W = $clog2(FRAME_LEN);

  typedef logic [IDX_W-1:0] idx_t;

endpackage

// File: rtl/sparse_mult_by_a_acc.sv
// Frame index counter and masked XOR accumulator.
// sum is the running result including the word presented this cycle.
module sparse_mult_by_a_acc #(
  parameter int WIDTH = 3 * sparse_mult_by_a_pkg::LANE_W,
  parameter int FRAME_LEN = sparse_mult_by_a_pkg::FRAME_LEN,
  parameter logic [FRAME_LEN-1:0] A_MASK = sparse_mult_by_a_pkg::A_MASK
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [WIDTH-1:0]                  data,
  input  logic                              accept,
  output sparse_mult_by_a_pkg::idx_t        idx,
  output logic                              last,
  output logic [WIDTH-1:0]                  sum
);
  import sparse_mult_by_a_pkg::*;

  localparam idx_t LAST = idx_t'(FRAME_LEN - 1);

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] base;

  // Word 0 starts a fresh sum so frames never leak into each other.
  always_comb begin
    base = (idx == '0) ? '0 : acc;
    sum  = A_MASK[idx] ? (base ^ data) : base;
    last = accept && (idx == LAST);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      idx <= '0;
      acc <= '0;
    end else if (accept) begin
      acc <= sum;
      idx <= (idx == LAST) ? '0 : idx + idx_t'(1);
    end
  end

endmodule

// File: rtl/sparse_mult_by_a.sv
// Sparse GF(2) multiply of one frame by a row of A; one result per frame.
// Optional simulation checks: define SPARSE_MULT_BY_A_ASSERT_EN.
module sparse_mult_by_a #(
  parameter int WIDTH = 3 * sparse_mult_by_a_pkg::LANE_W,
  parameter int FRAME_LEN = sparse_mult_by_a_pkg::FRAME_LEN,
  parameter logic [FRAME_LEN-1:0] A_MASK = sparse_mult_by_a_pkg::A_MASK
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_input_data,
  input  logic             i_input_valid,
  output logic             o_input_ready,
  output logic [WIDTH-1:0] o_output_data,
  output logic             o_output_valid,
  input  logic             i_output_ready
);
  import sparse_mult_by_a_pkg::*;

  localparam idx_t LAST = idx_t'(FRAME_LEN - 1);

  idx_t             idx;
  logic             last;
  logic             accept;
  logic             consume;
  logic [WIDTH-1:0] sum;

  sparse_mult_by_a_acc #(
    .WIDTH    (WIDTH),
    .FRAME_LEN(FRAME_LEN),
    .A_MASK   (A_MASK)
  ) u_acc (
    .clock (i_clock),
    .reset (i_reset),
    .data  (i_input_data),
    .accept(accept),
    .idx   (idx),
    .last  (last),
    .sum   (sum)
  );

  // Only the closing word of a frame can be blocked by an unread result.
  always_comb begin
    consume       = o_output_valid && i_output_ready;
    o_input_ready = !((idx == LAST) && o_output_valid && !i_output_ready);
    accept        = i_input_valid && o_input_ready;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_output_data  <= '0;
      o_output_valid <= 1'b0;
    end else if (last) begin
      o_output_data  <= sum;
      o_output_valid <= 1'b1;
    end else if (consume) begin
      o_output_valid <= 1'b0;
    end
  end

`ifdef SPARSE_MULT_BY_A_ASSERT_EN
  a_hold: assert property (
    @(posedge i_clock) disable iff (i_reset)
    o_output_valid && !i_output_ready |=>
      o_output_valid && $stable(o_output_data)
  );

  a_no_accept: assert property (
    @(posedge i_clock) disable iff (i_reset)
    !o_input_ready |=> $stable(idx)
  );

  a_idx_range: assert property (
    @(posedge i_clock) disable iff (i_reset)
    int'(idx) < FRAME_LEN
  );
`else
`endif

endmodule

// File: tb/tb_sparse_mult_by_a.sv
// Randomized bench for sparse_mult_by_a with a frame-level XOR model.
// Outputs are collected at handshake and compared per scenario.
module tb_sparse_mult_by_a;

  localparam int W = 96;
  localparam int FL = 11;
  localparam logic [FL-1:0] MASK = 11'b100_0000_0000;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready = 1'b1;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  int tests = 0;
  int fails = 0;

  logic [W-1:0] w10[5] = '{
    {32'd67108896, 32'd65536, 32'd134217792},
    {32'd96,       32'd65535, 32'd69696969},
    {32'd67108896, 32'd65534, 32'd250250},
    {32'd0,        32'd0,     32'd0},
    {32'd67108,    32'd65532, 32'd0}
  };

  sparse_mult_by_a dut (
    .i_clock       (clk),
    .i_reset       (rst),
    .i_input_data  (in_data),
    .i_input_valid (in_valid),
    .o_input_ready (in_ready),
    .o_output_data (out_data),
    .o_output_valid(out_valid),
    .i_output_ready(out_ready)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    #2;
    if (!rst && out_valid && out_ready) got_q.push_back(out_data);
  end

  function automatic logic [W-1:0] model(input logic [W-1:0] f[FL]);
    logic [W-1:0] r = '0;
    for (int k = 0; k < FL; k++)
      if (MASK[k]) r = r ^ f[k];
    return r;
  endfunction

  task automatic send(input logic [W-1:0] w);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data = w;
    #1;
    while (!in_ready && n < 500) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL send_timeout ready=%0b required=1", in_ready);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [W-1:0] last_word,
                            input int gapmax);
    logic [W-1:0] f[FL];
    for (int k = 0; k < FL - 1; k++) f[k] = {$urandom, $urandom, $urandom};
    f[FL-1] = last_word;
    exp_q.push_back(model(f));
    for (int k = 0; k < FL; k++) begin
      if (gapmax > 0) repeat ($urandom_range(gapmax, 0)) @(negedge clk);
      send(f[k]);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_valid got=%0b required=0", out_valid);
    end
    tests++;
    if (out_data !== '0) begin
      fails++;
      $display("FAIL reset_data got=%h required=0", out_data);
    end
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready got=%0b required=1", in_ready);
    end
  endtask

  task automatic test_idle();
    out_ready = 1'b1;
    repeat (100) @(negedge clk);
    tests++;
    if (got_q.size() != 0) begin
      fails++;
      $display("FAIL idle_count got=%0d required=0", got_q.size());
    end
  endtask

  task automatic test_backpressure();
    got_q.delete();
    out_ready = 1'b0;
    for (int k = 0; k < FL; k++) send('0);
    repeat (10) @(negedge clk);
    #1;
    tests++;
    if (got_q.size() != 0 || out_valid !== 1'b1) begin
      fails++;
      $display("FAIL bp_hold got=%0d/%0b required=0/1",
               got_q.size(), out_valid);
    end
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    tests++;
    if (got_q.size() != 1) begin
      fails++;
      $display("FAIL bp_count got=%0d required=1", got_q.size());
    end else if (got_q[0] !== '0) begin
      fails++;
      $display("FAIL bp_value got=%h required=0", got_q[0]);
    end
  endtask

  task automatic test_single();
    got_q.delete();
    exp_q.delete();
    send_frame(w10[0], 0);
    repeat (5) @(negedge clk);
    tests++;
    if (got_q.size() != 1) begin
      fails++;
      $display("FAIL single_count got=%0d required=1", got_q.size());
    end else if (got_q[0] !== exp_q[0] || got_q[0] !== w10[0]) begin
      fails++;
      $display("FAIL single_value got=%h required=%h", got_q[0], exp_q[0]);
    end
  endtask

  task automatic test_frames(input int gap, input string name);
    got_q.delete();
    exp_q.delete();
    for (int i = 0; i < 5; i++) begin
      send_frame(w10[i], 0);
      repeat (gap) @(negedge clk);
    end
    repeat (5) @(negedge clk);
    tests++;
    if (got_q.size() != 5) begin
      fails++;
      $display("FAIL %s_count got=%0d required=5", name, got_q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        tests++;
        if (got_q[i] !== exp_q[i]) begin
          fails++;
          $display("FAIL %s_out%0d got=%h required=%h",
                   name, i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_stall();
    logic [W-1:0] fb[FL];
    got_q.delete();
    exp_q.delete();
    out_ready = 1'b0;
    send_frame({$urandom, $urandom, $urandom}, 0);
    for (int k = 0; k < FL; k++) fb[k] = {$urandom, $urandom, $urandom};
    exp_q.push_back(model(fb));
    for (int k = 0; k < FL - 1; k++) send(fb[k]);
    @(negedge clk);
    #1;
    tests++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("FAIL stall_ready got=%0b required=0", in_ready);
    end
    fork
      send(fb[FL-1]);
      begin
        repeat (5) @(negedge clk);
        #1;
        tests++;
        if (in_ready !== 1'b0 || out_data !== exp_q[0]) begin
          fails++;
          $display("FAIL stall_hold got=%0b/%h required=0/%h",
                   in_ready, out_data, exp_q[0]);
        end
        @(negedge clk);
        out_ready = 1'b1;
      end
    join
    @(negedge clk);
    #1;
    tests++;
    if (out_valid !== 1'b1) begin
      fails++;
      $display("FAIL stall_nobubble got=%0b required=1", out_valid);
    end
    repeat (3) @(negedge clk);
    tests++;
    if (got_q.size() != 2) begin
      fails++;
      $display("FAIL stall_count got=%0d required=2", got_q.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        tests++;
        if (got_q[i] !== exp_q[i]) begin
          fails++;
          $display("FAIL stall_out%0d got=%h required=%h",
                   i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    bit done = 1'b0;
    got_q.delete();
    exp_q.delete();
    fork
      begin
        for (int i = 0; i < 6; i++)
          send_frame({$urandom, $urandom, $urandom}, 3);
        done = 1'b1;
      end
      while (!done) begin
        @(negedge clk);
        out_ready = 1'($urandom_range(1, 0));
      end
    join
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    tests++;
    if (got_q.size() != 6) begin
      fails++;
      $display("FAIL random_count got=%0d required=6", got_q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        tests++;
        if (got_q[i] !== exp_q[i]) begin
          fails++;
          $display("FAIL random_out%0d got=%h required=%h",
                   i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    got_q.delete();
    exp_q.delete();
    out_ready = 1'b0;
    send_frame({$urandom, $urandom, $urandom}, 0);
    for (int k = 0; k < 6; k++) send({$urandom, $urandom, $urandom});
    do_reset();
    out_ready = 1'b1;
    send_frame({$urandom, $urandom, $urandom}, 0);
    repeat (5) @(negedge clk);
    tests++;
    if (got_q.size() != 1) begin
      fails++;
      $display("FAIL rstmid_count got=%0d required=1", got_q.size());
    end else if (got_q[0] !== exp_q[0]) begin
      fails++;
      $display("FAIL rstmid_value got=%h required=%h", got_q[0], exp_q[0]);
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_backpressure();
    test_single();
    test_frames(0, "b2b");
    test_frames(20, "gaps");
    test_stall();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
